// File: rtl/cluster_pkg.sv
// Shared definitions for the 1536-pad cluster unpacker: geometry constants,
// decode FSM states and the per-slot address classifier.
package cluster_pkg;

  localparam int MXADRB = 11;
  localparam int MXVPF  = 1536;
  localparam int NSLOTS = 8;
  localparam logic [MXADRB-1:0] INVALID_ADR = 11'd2047;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC0 = 2'd1,
    ST_DEC1 = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SLOT_EMPTY   = 2'd0,
    SLOT_ILLEGAL = 2'd1,
    SLOT_VALID   = 2'd2
  } slot_class_t;

  // 2047 marks an unused slot; anything else past the map end is illegal.
  function automatic slot_class_t classify_slot(input logic [MXADRB-1:0] adr);
    if (adr == INVALID_ADR) begin
      return SLOT_EMPTY;
    end else if (int'(adr) >= MXVPF) begin
      return SLOT_ILLEGAL;
    end
    return SLOT_VALID;
  endfunction

endpackage

// File: rtl/adr_to_mask.sv
// Converts one cluster address into a one-hot (or short run) mask over the
// 1536-bit hit map. Out-of-range and empty addresses yield an all-zero mask.
// With CLUSTER_SIZE_EN defined, a 3-bit size extends the run to adr..adr+cnt;
// the left shift naturally clips anything beyond bit 1535.
module adr_to_mask
  import cluster_pkg::*;
(
  input  logic [MXADRB-1:0] adr_i,
`ifdef CLUSTER_SIZE_EN
  input  logic [2:0]        cnt_i,
`endif
  output logic [MXVPF-1:0]  mask_o
);

  logic             in_range;
  logic [MXVPF-1:0] run;

  assign in_range = (classify_slot(adr_i) == SLOT_VALID);

`ifdef CLUSTER_SIZE_EN
  assign run = {{(MXVPF-8){1'b0}}, (8'hff >> (3'd7 - cnt_i))};
`else
  assign run = {{(MXVPF-1){1'b0}}, 1'b1};
`endif

  assign mask_o = in_range ? (run << adr_i) : '0;

endmodule

// File: rtl/cluster_unpacker_1536.sv
// Rebuilds the 1536-bit vpf hit map from a frame of eight 11-bit cluster
// addresses. Decode takes two cycles (slots 0-3, then 4-7) through a shared
// bank of four mask generators; the map is published one cycle later.
// Optional build macro CLUSTER_SIZE_EN adds per-slot cluster sizes cnt0..cnt7.
module cluster_unpacker_1536
  import cluster_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clock4x,
  input  logic              global_reset_n,
  input  logic              adr_valid,
  input  logic [MXADRB-1:0] adr0,
  input  logic [MXADRB-1:0] adr1,
  input  logic [MXADRB-1:0] adr2,
  input  logic [MXADRB-1:0] adr3,
  input  logic [MXADRB-1:0] adr4,
  input  logic [MXADRB-1:0] adr5,
  input  logic [MXADRB-1:0] adr6,
  input  logic [MXADRB-1:0] adr7,
`ifdef CLUSTER_SIZE_EN
  input  logic [2:0]        cnt0,
  input  logic [2:0]        cnt1,
  input  logic [2:0]        cnt2,
  input  logic [2:0]        cnt3,
  input  logic [2:0]        cnt4,
  input  logic [2:0]        cnt5,
  input  logic [2:0]        cnt6,
  input  logic [2:0]        cnt7,
`endif
  output logic              busy,
  output logic [MXVPF-1:0]  vpfs_out,
  output logic              vpfs_valid,
  output logic [3:0]        n_hits,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Saturating accumulate; the counters stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [3:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-3){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  state_t             state_q;
  logic               busy_q;
  logic               vpfs_valid_q;
  logic [MXVPF-1:0]   work_q;
  logic [MXVPF-1:0]   vpfs_out_q;
  logic [3:0]         n_hits_q;
  logic [3:0]         hits_pend_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [CNT_W-1:0]   drop_cnt_q;
  logic [MXADRB-1:0]  adr_q  [NSLOTS];

  logic [MXADRB-1:0]  adr_in [NSLOTS];
  logic [MXADRB-1:0]  dec_adr [4];
  logic [MXVPF-1:0]   mask    [4];
  logic [MXVPF-1:0]   mask_or;
  logic [3:0]         frame_hits_d;
  logic [3:0]         frame_errs_d;
  logic               accept;
  logic               drop;

  assign adr_in[0] = adr0;
  assign adr_in[1] = adr1;
  assign adr_in[2] = adr2;
  assign adr_in[3] = adr3;
  assign adr_in[4] = adr4;
  assign adr_in[5] = adr5;
  assign adr_in[6] = adr6;
  assign adr_in[7] = adr7;

`ifdef CLUSTER_SIZE_EN
  logic [2:0] cnt_in [NSLOTS];
  logic [2:0] cnt_q  [NSLOTS];
  logic [2:0] dec_cnt [4];

  assign cnt_in[0] = cnt0;
  assign cnt_in[1] = cnt1;
  assign cnt_in[2] = cnt2;
  assign cnt_in[3] = cnt3;
  assign cnt_in[4] = cnt4;
  assign cnt_in[5] = cnt5;
  assign cnt_in[6] = cnt6;
  assign cnt_in[7] = cnt7;

  // Size registers follow the address latch; they only matter while decoding.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int s = 0; s < NSLOTS; s++) cnt_q[s] <= '0;
    end else if (accept) begin
      for (int s = 0; s < NSLOTS; s++) cnt_q[s] <= cnt_in[s];
    end
  end

  // Route the size of the half-frame being decoded to the mask bank.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dec_cnt[k] = (state_q == ST_DEC1) ? cnt_q[k+4] : cnt_q[k];
    end
  end
`endif

  // Per-frame hit and illegal-slot tallies, taken from the inputs at accept time.
  always_comb begin
    frame_hits_d = '0;
    frame_errs_d = '0;
    for (int s = 0; s < NSLOTS; s++) begin
      case (classify_slot(adr_in[s]))
        SLOT_VALID:   frame_hits_d = frame_hits_d + 4'd1;
        SLOT_ILLEGAL: frame_errs_d = frame_errs_d + 4'd1;
        default:      ;
      endcase
    end
  end

  // DEC0 feeds slots 0-3 into the shared mask bank, DEC1 feeds slots 4-7.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      dec_adr[k] = (state_q == ST_DEC1) ? adr_q[k+4] : adr_q[k];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_mask
    adr_to_mask u_mask (
      .adr_i  (dec_adr[k]),
`ifdef CLUSTER_SIZE_EN
      .cnt_i  (dec_cnt[k]),
`endif
      .mask_o (mask[k])
    );
  end

  assign mask_or = mask[0] | mask[1] | mask[2] | mask[3];

  // A frame is taken in IDLE or OUT; offered during DEC0/DEC1 it is dropped.
  assign accept = adr_valid && ((state_q == ST_IDLE) || (state_q == ST_OUT));
  assign drop   = adr_valid && ((state_q == ST_DEC0) || (state_q == ST_DEC1));

  // Decode FSM with registered outputs, working map and counters.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      vpfs_valid_q <= 1'b0;
      work_q       <= '0;
      vpfs_out_q   <= '0;
      n_hits_q     <= '0;
      hits_pend_q  <= '0;
      err_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      for (int s = 0; s < NSLOTS; s++) adr_q[s] <= INVALID_ADR;
    end else begin
      vpfs_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
        end
        ST_DEC0: begin
          work_q  <= work_q | mask_or;
          state_q <= ST_DEC1;
          busy_q  <= 1'b1;
        end
        ST_DEC1: begin
          work_q  <= work_q | mask_or;
          state_q <= ST_OUT;
          busy_q  <= 1'b0;
        end
        ST_OUT: begin
          vpfs_out_q   <= work_q;
          n_hits_q     <= hits_pend_q;
          vpfs_valid_q <= 1'b1;
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (accept) begin
        state_q     <= ST_DEC0;
        busy_q      <= 1'b1;
        work_q      <= '0;
        hits_pend_q <= frame_hits_d;
        err_cnt_q   <= sat_add(err_cnt_q, frame_errs_d);
        for (int s = 0; s < NSLOTS; s++) adr_q[s] <= adr_in[s];
      end

      if (drop) begin
        drop_cnt_q <= sat_add(drop_cnt_q, 4'd1);
      end
    end
  end

  assign busy       = busy_q;
  assign vpfs_out   = vpfs_out_q;
  assign vpfs_valid = vpfs_valid_q;
  assign n_hits     = n_hits_q;
  assign err_cnt    = err_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cluster_unpacker_1536.sv
// Directed bench for cluster_unpacker_1536: a vector table of single frames
// plus hand-written sequences for drop, saturation and mid-frame reset.
// Build with CLUSTER_SIZE_EN defined to also exercise cluster sizes.
module tb_cluster_unpacker_1536;
  import cluster_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              adr_valid = 1'b0;
  logic [10:0]       adr_drv [8];
  logic [2:0]        cnt_drv [8];
  logic              busy;
  logic [MXVPF-1:0]  vpfs_out;
  logic              vpfs_valid;
  logic [3:0]        n_hits;
  logic [7:0]        err_cnt;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  cluster_unpacker_1536 dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .adr_valid      (adr_valid),
    .adr0           (adr_drv[0]),
    .adr1           (adr_drv[1]),
    .adr2           (adr_drv[2]),
    .adr3           (adr_drv[3]),
    .adr4           (adr_drv[4]),
    .adr5           (adr_drv[5]),
    .adr6           (adr_drv[6]),
    .adr7           (adr_drv[7]),
`ifdef CLUSTER_SIZE_EN
    .cnt0           (cnt_drv[0]),
    .cnt1           (cnt_drv[1]),
    .cnt2           (cnt_drv[2]),
    .cnt3           (cnt_drv[3]),
    .cnt4           (cnt_drv[4]),
    .cnt5           (cnt_drv[5]),
    .cnt6           (cnt_drv[6]),
    .cnt7           (cnt_drv[7]),
`endif
    .busy           (busy),
    .vpfs_out       (vpfs_out),
    .vpfs_valid     (vpfs_valid),
    .n_hits         (n_hits),
    .err_cnt        (err_cnt),
    .drop_cnt       (drop_cnt)
  );

  typedef struct {
    logic [7:0][10:0] adr;
    logic [MXVPF-1:0] map;
    int               hits;
    int               errs;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_map(input string nm, input logic [MXVPF-1:0] act,
                           input logic [MXVPF-1:0] exp);
    int first;
    checks++;
    if (act !== exp) begin
      errors++;
      first = -1;
      for (int b = 0; b < MXVPF; b++) begin
        if (first < 0 && act[b] !== exp[b]) first = b;
      end
      $display("FAIL %s: first differing bit %0d got %b expected %b, low word got %h expected %h",
               nm, first, act[first], exp[first], act[63:0], exp[63:0]);
    end
  endtask

  task automatic clear_slots();
    for (int s = 0; s < 8; s++) begin
      adr_drv[s] = 11'd2047;
      cnt_drv[s] = 3'd0;
    end
  endtask

  // One isolated frame from IDLE: accept at N, result checked just after N+3.
  task automatic do_frame(input string nm, input logic [MXVPF-1:0] exp_map,
                          input int exp_hits, input int exp_errs);
    @(negedge clk); adr_valid = 1'b1;
    @(posedge clk); #1;
    check({nm, "_busy_n"}, busy, 1);
    @(negedge clk); adr_valid = 1'b0;
    @(posedge clk); #1;
    check({nm, "_valid_n1"}, vpfs_valid, 0);
    @(posedge clk); #1;
    check({nm, "_valid_n2"}, vpfs_valid, 0);
    check({nm, "_busy_n2"}, busy, 0);
    @(posedge clk); #1;
    check({nm, "_valid_n3"}, vpfs_valid, 1);
    check_map({nm, "_map"}, vpfs_out, exp_map);
    check({nm, "_hits"}, n_hits, exp_hits);
    check({nm, "_err"}, err_cnt, exp_errs);
  endtask

  initial begin
    logic [MXVPF-1:0] m;
    clear_slots();

    // Vector table
    for (int i = 0; i < 5; i++) begin
      vecs[i].adr = {8{11'd2047}};
      vecs[i].map = '0;
    end
    vecs[0].hits = 0; vecs[0].errs = 0;
    for (int s = 0; s < 8; s++) vecs[1].adr[s] = 11'(8 * s);
    vecs[1].map[63:0] = 64'h0101010101010101;
    vecs[1].hits = 8; vecs[1].errs = 0;
    vecs[2].adr[0] = 11'd1535; vecs[2].adr[1] = 11'd1536; vecs[2].adr[2] = 11'd2046;
    vecs[2].map[1535] = 1'b1;
    vecs[2].hits = 1; vecs[2].errs = 2;
    vecs[3].adr[0] = 11'd5; vecs[3].adr[1] = 11'd5; vecs[3].adr[2] = 11'd1000;
    vecs[3].map[5] = 1'b1; vecs[3].map[1000] = 1'b1;
    vecs[3].hits = 3; vecs[3].errs = 0;
    vecs[4].adr[0] = 11'd1535; vecs[4].adr[1] = 11'd0; vecs[4].adr[2] = 11'd767;
    vecs[4].adr[5] = 11'd2000;
    vecs[4].map[1535] = 1'b1; vecs[4].map[0] = 1'b1; vecs[4].map[767] = 1'b1;
    vecs[4].hits = 3; vecs[4].errs = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", vpfs_valid, 0);
    check_map("rst_map", vpfs_out, '0);
    check("rst_hits", n_hits, 0);
    check("rst_err", err_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 8; s++) adr_drv[s] = vecs[i].adr[s];
      exp_err = exp_err + vecs[i].errs;
      do_frame($sformatf("vec%0d", i), vecs[i].map, vecs[i].hits, exp_err);
    end

    // Back-to-back: second frame dropped, frame offered in OUT accepted
    @(negedge clk);
    clear_slots(); adr_drv[0] = 11'd10; adr_valid = 1'b1;
    @(posedge clk); #1;
    check("drop_busy_n", busy, 1);
    @(negedge clk);
    adr_drv[0] = 11'd20; adr_drv[1] = 11'd1600;
    @(posedge clk); #1;
    check("drop_busy_n1", busy, 1);
    check("drop_cnt_n1", drop_cnt, 1);
    @(negedge clk); adr_valid = 1'b0;
    @(posedge clk); #1;
    check("drop_busy_n2", busy, 0);
    @(negedge clk);
    clear_slots(); adr_drv[0] = 11'd30; adr_valid = 1'b1;
    @(posedge clk); #1;
    m = '0; m[10] = 1'b1;
    check("drop_valid_n3", vpfs_valid, 1);
    check_map("drop_map_n3", vpfs_out, m);
    check("drop_hits_n3", n_hits, 1);
    check("drop_err_n3", err_cnt, exp_err);
    check("drop_cnt_n3", drop_cnt, 1);
    check("drop_busy_n3", busy, 1);
    @(negedge clk); adr_valid = 1'b0;
    @(posedge clk); #1;
    check("out_valid_n4", vpfs_valid, 0);
    @(posedge clk); #1;
    check("out_valid_n5", vpfs_valid, 0);
    @(posedge clk); #1;
    m = '0; m[30] = 1'b1;
    check("out_valid_n6", vpfs_valid, 1);
    check_map("out_map_n6", vpfs_out, m);
    @(posedge clk); #1;
    check("hold_valid", vpfs_valid, 0);
    check_map("hold_map", vpfs_out, m);
    check("hold_hits", n_hits, 1);

`ifdef CLUSTER_SIZE_EN
    // Cluster sizes: run clipped at the top of the map
    clear_slots();
    adr_drv[0] = 11'd1533; cnt_drv[0] = 3'd7;
    adr_drv[1] = 11'd100;  cnt_drv[1] = 3'd3;
    m = '0;
    m[1533] = 1'b1; m[1534] = 1'b1; m[1535] = 1'b1;
    m[100] = 1'b1; m[101] = 1'b1; m[102] = 1'b1; m[103] = 1'b1;
    do_frame("size", m, 2, exp_err);
    clear_slots();
`endif

    // err_cnt saturation: 300 frames with one illegal slot each
    clear_slots(); adr_drv[3] = 11'd1700; adr_drv[4] = 11'd42;
    m = '0; m[42] = 1'b1;
    for (int f = 0; f < 300; f++) begin
      exp_err = (exp_err + 1 > 255) ? 255 : exp_err + 1;
      do_frame("errsat", m, 1, exp_err);
    end
    check("errsat_final", err_cnt, 255);

    // drop_cnt saturation: strobe held high continuously
    clear_slots();
    @(negedge clk); adr_valid = 1'b1;
    repeat (450) @(posedge clk);
    @(negedge clk); adr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("dropsat_final", drop_cnt, 255);
    check("dropsat_err", err_cnt, 255);

    // Reset during decode aborts the frame
    clear_slots(); adr_drv[0] = 11'd77;
    @(negedge clk); adr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); adr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_valid_in_rst", vpfs_valid, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_valid_after", vpfs_valid, 0);
    end
    check("abort_busy", busy, 0);
    check_map("abort_map", vpfs_out, '0);
    check("abort_hits", n_hits, 0);
    check("abort_err", err_cnt, 0);
    check("abort_drop", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
